// File: rtl/wfg_mem_bank_if.sv
// Wishbone slave bundle for the waveform memory bank (byte address, DW data, byte selects).
interface wfg_mem_bank_if #(
    parameter int DW = 32
);
    localparam int MW = DW / 8;

    logic [31:0]   io_wbs_adr;
    logic [DW-1:0] io_wbs_datwr;
    logic [DW-1:0] io_wbs_datrd;
    logic          io_wbs_we;
    logic [MW-1:0] io_wbs_sel;
    logic          io_wbs_stb;
    logic          io_wbs_cyc;
    logic          io_wbs_ack;

    modport master (
        output io_wbs_adr, io_wbs_datwr, io_wbs_we, io_wbs_sel, io_wbs_stb, io_wbs_cyc,
        input  io_wbs_datrd, io_wbs_ack
    );

    modport slave (
        input  io_wbs_adr, io_wbs_datwr, io_wbs_we, io_wbs_sel, io_wbs_stb, io_wbs_cyc,
        output io_wbs_datrd, io_wbs_ack
    );
endinterface

// File: rtl/wfg_mem_bank.sv
// Maps a flat word address space onto NUM_BANKS dual-port SRAM macros:
// port1 serves the core read stream, port0 is a Wishbone slave for load/readback.
module wfg_mem_bank #(
    parameter int          NUM_BANKS = 2,
    parameter int          BANK_AW   = 9,
    parameter int          DW        = 32,
    parameter logic [31:0] MEM_BASE  = 32'h3010_0000,
    localparam int         BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int         AW        = BANK_AW + BW,
    localparam int         MW        = DW / 8
) (
    input  logic                           io_wbs_clk,
    input  logic                           io_wbs_rst,
    input  logic                           csb_i,
    input  logic [AW-1:0]                  addr_i,
    output logic [DW-1:0]                  dout_o,
    output logic                           dout_valid_o,
    wfg_mem_bank_if.slave                  wbs,
    output logic [NUM_BANKS-1:0]           mem_csb0_o,
    output logic [NUM_BANKS-1:0]           mem_web0_o,
    output logic [NUM_BANKS*MW-1:0]        mem_wmask0_o,
    output logic [NUM_BANKS*BANK_AW-1:0]   mem_addr0_o,
    output logic [NUM_BANKS*DW-1:0]        mem_din0_o,
    input  logic [NUM_BANKS*DW-1:0]        mem_dout0_i,
    output logic [NUM_BANKS-1:0]           mem_csb1_o,
    output logic [NUM_BANKS*BANK_AW-1:0]   mem_addr1_o,
    input  logic [NUM_BANKS*DW-1:0]        mem_dout1_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_WR,
        S_ISSUE_RD,
        S_RD_WAIT,
        S_ACK
    } state_t;

    state_t                  state_q, state_d;
    logic                    rd_q, rd_d;
    logic [BW-1:0]           sel_q, sel_d;
    logic [NUM_BANKS-1:0]    csb0_q, csb0_d;
    logic [NUM_BANKS-1:0]    web0_q, web0_d;
    logic [NUM_BANKS*MW-1:0] wmask0_q, wmask0_d;
    logic [BANK_AW-1:0]      addr0_q, addr0_d;
    logic [DW-1:0]           din0_q, din0_d;
    logic [BW-1:0]           wb_bank_q, wb_bank_d;
    logic                    ack_q, ack_d;
    logic [DW-1:0]           datrd_q, datrd_d;

    logic [BW-1:0]           rd_bank;
    logic                    hit;
    logic [AW-1:0]           wb_word;
    logic [BW-1:0]           wb_bank;
    logic [BANK_AW-1:0]      wb_off;
    logic                    unused_adr;

    assign rd_bank    = addr_i[AW-1:BANK_AW];
    assign hit        = wbs.io_wbs_cyc & wbs.io_wbs_stb &
                        (wbs.io_wbs_adr[31:AW+2] == MEM_BASE[31:AW+2]);
    assign wb_word    = wbs.io_wbs_adr[AW+1:2];
    assign wb_bank    = wb_word[AW-1:BANK_AW];
    assign wb_off     = wb_word[BANK_AW-1:0];
    assign unused_adr = ^wbs.io_wbs_adr[1:0];

    // Core read path: chip select is combinational, bank steering for the data is registered.
    always_comb begin
        mem_csb1_o = '1;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            if (int'(rd_bank) == int'(k)) mem_csb1_o[k] = csb_i;
        end
        mem_addr1_o = {NUM_BANKS{addr_i[BANK_AW-1:0]}};
        rd_d        = ~csb_i;
        sel_d       = csb_i ? sel_q : rd_bank;
        dout_o      = '0;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            if (int'(sel_q) == int'(k)) dout_o = mem_dout1_i[k*DW +: DW];
        end
    end

    // Port0 strobes are registered, so the macro sees them one cycle after the request edge.
    always_comb begin
        state_d   = state_q;
        csb0_d    = '1;
        web0_d    = '1;
        wmask0_d  = '0;
        addr0_d   = addr0_q;
        din0_d    = din0_q;
        wb_bank_d = wb_bank_q;
        ack_d     = 1'b0;
        datrd_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    addr0_d   = wb_off;
                    din0_d    = wbs.io_wbs_datwr;
                    wb_bank_d = wb_bank;
                    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
                        if (int'(wb_bank) == int'(k)) begin
                            csb0_d[k]            = 1'b0;
                            web0_d[k]            = ~wbs.io_wbs_we;
                            wmask0_d[k*MW +: MW] = wbs.io_wbs_sel;
                        end
                    end
                    state_d = wbs.io_wbs_we ? S_ISSUE_WR : S_ISSUE_RD;
                end
            end
            S_ISSUE_WR: begin
                ack_d   = 1'b1;
                state_d = S_ACK;
            end
            S_ISSUE_RD: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (!wbs.io_wbs_cyc) begin
                    state_d = S_IDLE;
                end else begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
                        if (int'(wb_bank_q) == int'(k)) datrd_d = mem_dout0_i[k*DW +: DW];
                    end
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
        if (io_wbs_rst) begin
            state_q   <= S_IDLE;
            rd_q      <= 1'b0;
            sel_q     <= '0;
            csb0_q    <= '1;
            web0_q    <= '1;
            wmask0_q  <= '0;
            addr0_q   <= '0;
            din0_q    <= '0;
            wb_bank_q <= '0;
            ack_q     <= 1'b0;
            datrd_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            sel_q     <= sel_d;
            csb0_q    <= csb0_d;
            web0_q    <= web0_d;
            wmask0_q  <= wmask0_d;
            addr0_q   <= addr0_d;
            din0_q    <= din0_d;
            wb_bank_q <= wb_bank_d;
            ack_q     <= ack_d;
            datrd_q   <= datrd_d;
        end
    end

    assign dout_valid_o     = rd_q;
    assign mem_csb0_o       = csb0_q;
    assign mem_web0_o       = web0_q;
    assign mem_wmask0_o     = wmask0_q;
    assign mem_addr0_o      = {NUM_BANKS{addr0_q}};
    assign mem_din0_o       = {NUM_BANKS{din0_q}};
    assign wbs.io_wbs_ack   = ack_q;
    assign wbs.io_wbs_datrd = datrd_q;

endmodule
